// File: rtl/cache_refill_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the cache line refill controller.
package cache_refill_ctrl_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_WORD_W   = 32;
  localparam int DEF_OFFSET_W = 2;
  localparam int DEF_INDEX_W  = 3;
  localparam int DEF_WAYS     = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_FILL = 3'd2,
    ST_TAG  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss handler: fetches a whole line word by word (critical word first, wrapping),
// strobes each word into the victim way, then writes tag+valid and pulses refill_done.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int WAYS     = DEF_WAYS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 miss_req,
  input  logic [ADDR_W-1:0]                    miss_addr,
  input  logic [WAYS-1:0]                      victim_way,
  output logic                                 busy,
  output logic                                 mem_rd_req,
  output logic [ADDR_W-1:0]                    mem_rd_addr,
  input  logic                                 mem_rd_ack,
  input  logic [WORD_W-1:0]                    mem_rd_data,
  output logic                                 fill_en,
  output logic [WAYS-1:0]                      fill_way,
  output logic [INDEX_W-1:0]                   fill_index,
  output logic [OFFSET_W-1:0]                  fill_word,
  output logic [WORD_W-1:0]                    fill_data,
  output logic                                 tag_wr_en,
  output logic [ADDR_W-INDEX_W-OFFSET_W-3:0]   tag_wr_data,
  output logic                                 cpu_word_vld,
  output logic [WORD_W-1:0]                    cpu_word,
  output logic                                 refill_done
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;

  state_e                state_q;
  logic [OFFSET_W-1:0]   crit_q;
  logic [OFFSET_W-1:0]   wcnt_q;
  logic [OFFSET_W-1:0]   word_d;
  logic [OFFSET_W-1:0]   next_word_d;

  logic                  busy_q;
  logic                  mem_rd_req_q;
  logic [ADDR_W-1:0]     mem_rd_addr_q;
  logic                  fill_en_q;
  logic [WAYS-1:0]       fill_way_q;
  logic [INDEX_W-1:0]    fill_index_q;
  logic [OFFSET_W-1:0]   fill_word_q;
  logic [WORD_W-1:0]     fill_data_q;
  logic                  tag_wr_en_q;
  logic [TAG_W-1:0]      tag_wr_data_q;
  logic                  cpu_word_vld_q;
  logic [WORD_W-1:0]     cpu_word_q;
  logic                  refill_done_q;

  logic [TAG_W-1:0]      miss_tag;
  logic [INDEX_W-1:0]    miss_index;
  logic [OFFSET_W-1:0]   miss_offset;
  logic                  unused_byte_bits;

  assign miss_tag         = miss_addr[ADDR_W-1 -: TAG_W];
  assign miss_index       = miss_addr[OFFSET_W+2 +: INDEX_W];
  assign miss_offset      = miss_addr[2 +: OFFSET_W];
  // Byte offset within a word never matters: memory is read whole words.
  assign unused_byte_bits = ^miss_addr[1:0];

  // Wrap-around word position: modulo N falls out of the OFFSET_W-bit width.
  always_comb begin
    word_d      = crit_q + wcnt_q;
    next_word_d = word_d + OFFSET_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      crit_q         <= '0;
      wcnt_q         <= '0;
      busy_q         <= 1'b0;
      mem_rd_req_q   <= 1'b0;
      mem_rd_addr_q  <= '0;
      fill_en_q      <= 1'b0;
      fill_way_q     <= '0;
      fill_index_q   <= '0;
      fill_word_q    <= '0;
      fill_data_q    <= '0;
      tag_wr_en_q    <= 1'b0;
      tag_wr_data_q  <= '0;
      cpu_word_vld_q <= 1'b0;
      cpu_word_q     <= '0;
      refill_done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_req) begin
            state_q       <= ST_REQ;
            crit_q        <= miss_offset;
            wcnt_q        <= '0;
            busy_q        <= 1'b1;
            fill_way_q    <= victim_way;
            fill_index_q  <= miss_index;
            tag_wr_data_q <= miss_tag;
            mem_rd_req_q  <= 1'b1;
            mem_rd_addr_q <= {miss_tag, miss_index, miss_offset, 2'b00};
          end
        end
        ST_REQ: begin
          if (mem_rd_ack) begin
            state_q      <= ST_FILL;
            mem_rd_req_q <= 1'b0;
            fill_en_q    <= 1'b1;
            fill_word_q  <= word_d;
            fill_data_q  <= mem_rd_data;
            if (wcnt_q == '0) begin
              cpu_word_vld_q <= 1'b1;
              cpu_word_q     <= mem_rd_data;
            end
          end
        end
        ST_FILL: begin
          fill_en_q      <= 1'b0;
          cpu_word_vld_q <= 1'b0;
          wcnt_q         <= wcnt_q + OFFSET_W'(1);
          if (wcnt_q == '1) begin
            state_q     <= ST_TAG;
            tag_wr_en_q <= 1'b1;
          end else begin
            state_q       <= ST_REQ;
            mem_rd_req_q  <= 1'b1;
            mem_rd_addr_q <= {tag_wr_data_q, fill_index_q, next_word_d, 2'b00};
          end
        end
        ST_TAG: begin
          state_q       <= ST_DONE;
          tag_wr_en_q   <= 1'b0;
          refill_done_q <= 1'b1;
        end
        ST_DONE: begin
          state_q       <= ST_IDLE;
          refill_done_q <= 1'b0;
          busy_q        <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign mem_rd_req   = mem_rd_req_q;
  assign mem_rd_addr  = mem_rd_addr_q;
  assign fill_en      = fill_en_q;
  assign fill_way     = fill_way_q;
  assign fill_index   = fill_index_q;
  assign fill_word    = fill_word_q;
  assign fill_data    = fill_data_q;
  assign tag_wr_en    = tag_wr_en_q;
  assign tag_wr_data  = tag_wr_data_q;
  assign cpu_word_vld = cpu_word_vld_q;
  assign cpu_word     = cpu_word_q;
  assign refill_done  = refill_done_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: memory model plus a queue of expected fills.
module tb_cache_refill_ctrl;

  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 3;
  localparam int WAYS     = 4;
  localparam int N        = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  miss_req;
  logic [ADDR_W-1:0]     miss_addr;
  logic [WAYS-1:0]       victim_way;
  logic                  busy;
  logic                  mem_rd_req;
  logic [ADDR_W-1:0]     mem_rd_addr;
  logic                  mem_rd_ack;
  logic [WORD_W-1:0]     mem_rd_data;
  logic                  fill_en;
  logic [WAYS-1:0]       fill_way;
  logic [INDEX_W-1:0]    fill_index;
  logic [OFFSET_W-1:0]   fill_word;
  logic [WORD_W-1:0]     fill_data;
  logic                  tag_wr_en;
  logic [TAG_W-1:0]      tag_wr_data;
  logic                  cpu_word_vld;
  logic [WORD_W-1:0]     cpu_word;
  logic                  refill_done;

  cache_refill_ctrl #(
    .ADDR_W  (ADDR_W),
    .WORD_W  (WORD_W),
    .OFFSET_W(OFFSET_W),
    .INDEX_W (INDEX_W),
    .WAYS    (WAYS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .miss_req    (miss_req),
    .miss_addr   (miss_addr),
    .victim_way  (victim_way),
    .busy        (busy),
    .mem_rd_req  (mem_rd_req),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_ack  (mem_rd_ack),
    .mem_rd_data (mem_rd_data),
    .fill_en     (fill_en),
    .fill_way    (fill_way),
    .fill_index  (fill_index),
    .fill_word   (fill_word),
    .fill_data   (fill_data),
    .tag_wr_en   (tag_wr_en),
    .tag_wr_data (tag_wr_data),
    .cpu_word_vld(cpu_word_vld),
    .cpu_word    (cpu_word),
    .refill_done (refill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  word;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  way;
    logic [2:0]  index;
  } fill_t;

  fill_t fill_q[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h00_0000};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_req"}, mem_rd_req, 0);
    chk({pfx, "_addr"}, mem_rd_addr, 0);
    chk({pfx, "_fill_en"}, fill_en, 0);
    chk({pfx, "_fill_way"}, fill_way, 0);
    chk({pfx, "_fill_index"}, fill_index, 0);
    chk({pfx, "_fill_word"}, fill_word, 0);
    chk({pfx, "_fill_data"}, fill_data, 0);
    chk({pfx, "_tag_en"}, tag_wr_en, 0);
    chk({pfx, "_tag_data"}, tag_wr_data, 0);
    chk({pfx, "_cpu_vld"}, cpu_word_vld, 0);
    chk({pfx, "_cpu_word"}, cpu_word, 0);
    chk({pfx, "_done"}, refill_done, 0);
  endtask

  // Starts a miss from an IDLE sample point and services it until refill_done.
  // abort_fill>0 returns right after that many fill strobes have been seen.
  task automatic run_refill(input logic [31:0] addr, input logic [3:0] way, input int wait_n,
                            input bit spur, input int abort_fill, input int exp_lat);
    int         c      = 0;
    int         fills  = 0;
    int         tags   = 0;
    int         waited = 0;
    bit         done   = 0;
    bit         first  = 1;
    logic [1:0] crit   = addr[3:2];
    fill_t      f;
    for (int k = 0; k < N; k++) begin
      f.word  = crit + 2'(k);
      f.addr  = {addr[31:4], f.word, 2'b00};
      f.data  = mem_word(f.addr);
      f.way   = way;
      f.index = addr[6:4];
      fill_q.push_back(f);
    end
    miss_req   = 1'b1;
    miss_addr  = addr;
    victim_way = way;
    mem_rd_ack = 1'b0;
    while (!done && c < 200) begin
      tick;
      c++;
      mem_rd_ack  = 1'b0;
      mem_rd_data = '0;
      chk("excl_enables", fill_en & tag_wr_en, 0);
      chk("busy_in_refill", busy, 1);
      if (c == 1) chk("req_latency", mem_rd_req, 1);
      if (mem_rd_req) begin
        if (fill_q.size() == 0) chk("req_extra", 1, 0);
        else begin
          chk("rd_addr", mem_rd_addr, fill_q[0].addr);
          if (waited == wait_n) begin
            mem_rd_ack  = 1'b1;
            mem_rd_data = fill_q[0].data;
            waited      = 0;
          end else waited++;
        end
      end else if (spur) begin
        mem_rd_ack  = 1'b1;
        mem_rd_data = 32'hDEAD_BEEF;
      end
      if (fill_en) begin
        fills++;
        if (fill_q.size() == 0) chk("fill_extra", 1, 0);
        else begin
          f = fill_q.pop_front();
          chk("fill_word", fill_word, f.word);
          chk("fill_data", fill_data, f.data);
          chk("fill_way", fill_way, f.way);
          chk("fill_index", fill_index, f.index);
          chk("cpu_vld", cpu_word_vld, first);
          if (first) chk("cpu_word", cpu_word, f.data);
          first = 0;
        end
        if (fills == abort_fill) return;
      end else chk("cpu_vld_quiet", cpu_word_vld, 0);
      if (tag_wr_en) begin
        tags++;
        chk("tag_data", tag_wr_data, addr[31:7]);
        chk("tag_after_fills", fill_q.size(), 0);
      end
      if (refill_done) begin
        done = 1;
        chk("done_latency", c, exp_lat);
        miss_req = 1'b0;
      end
    end
    chk("done_seen", done, 1);
    chk("fill_count", fills, N);
    chk("tag_count", tags, 1);
  endtask

  initial begin
    reset       = 1'b0;
    miss_req    = 1'b0;
    miss_addr   = '0;
    victim_way  = '0;
    mem_rd_ack  = 1'b0;
    mem_rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    tick;
    chk("idle_busy", busy, 0);

    // Zero-wait refill, offset 2.
    run_refill(32'h0000_0048, 4'b0010, 0, 0, 0, 10);
    tick;
    chk("idle_after_t1", busy, 0);

    // Three wait cycles per word, unaligned byte address.
    run_refill(32'h1234_567B, 4'b0100, 3, 0, 0, 22);
    tick;
    chk("idle_after_t2", busy, 0);

    // Spurious acks in IDLE, then during FILL/TAG/DONE of a refill.
    mem_rd_ack  = 1'b1;
    mem_rd_data = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("spur_idle_busy", busy, 0);
      chk("spur_idle_fill", fill_en, 0);
      chk("spur_idle_req", mem_rd_req, 0);
    end
    mem_rd_ack = 1'b0;
    run_refill(32'h0000_0004, 4'b1000, 0, 1, 0, 10);
    mem_rd_ack = 1'b0;
    tick;
    chk("idle_after_t4", busy, 0);

    // Reset in the 2nd FILL cycle: outputs clear asynchronously, no tag write.
    run_refill(32'h0000_0A3C, 4'b0100, 0, 0, 2, 0);
    mem_rd_ack = 1'b0;
    reset      = 1'b0;
    #1;
    chk_all_zero("async_rst");
    miss_req = 1'b0;
    fill_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_no_tag", tag_wr_en, 0);
    end
    reset = 1'b1;
    tick;
    chk("idle_after_rst", busy, 0);

    // Offset 3 wraps 3,0,1,2; doubles as the restart-after-reset refill.
    run_refill(32'hFFFF_FFFC, 4'b0001, 0, 0, 0, 10);
    tick;
    chk("b2b_gap", busy, 0);
    // Back-to-back: new miss raised in the single IDLE cycle after refill_done.
    run_refill(32'h0000_0050, 4'b0010, 0, 0, 0, 10);
    tick;
    chk("idle_final", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
